// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key event decoder.
//   - scan-code constants for the E0/F0 prefixes, shift keys and caps lock
//   - prefix-state enum used by the decoder FSM
//   - key event struct carried through the event FIFO
//   - ps2_ascii(): set 2 scan code to ASCII for letters, digits and space
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;
   localparam logic [7:0] PS2_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } ps2_state_e;

   typedef struct packed {
      logic       ext;       // E0-prefixed key
      logic       is_break;  // key release
      logic [7:0] code;      // final scan code byte
      logic [7:0] ascii;     // translation, 0 if unmapped
   } ps2_event_t;

   localparam int unsigned PS2_EVENT_W = $bits(ps2_event_t);

   // Letters return lowercase unless upper is set; digits and space ignore upper.
   function automatic logic [7:0] ps2_ascii(input logic [7:0] code, input logic upper);
      logic [7:0] letter;
      logic [7:0] other;
      letter = 8'h00;
      other  = 8'h00;
      case (code)
         8'h1C: letter = 8'h61; // a
         8'h32: letter = 8'h62; // b
         8'h21: letter = 8'h63; // c
         8'h23: letter = 8'h64; // d
         8'h24: letter = 8'h65; // e
         8'h2B: letter = 8'h66; // f
         8'h34: letter = 8'h67; // g
         8'h33: letter = 8'h68; // h
         8'h43: letter = 8'h69; // i
         8'h3B: letter = 8'h6A; // j
         8'h42: letter = 8'h6B; // k
         8'h4B: letter = 8'h6C; // l
         8'h3A: letter = 8'h6D; // m
         8'h31: letter = 8'h6E; // n
         8'h44: letter = 8'h6F; // o
         8'h4D: letter = 8'h70; // p
         8'h15: letter = 8'h71; // q
         8'h2D: letter = 8'h72; // r
         8'h1B: letter = 8'h73; // s
         8'h2C: letter = 8'h74; // t
         8'h3C: letter = 8'h75; // u
         8'h2A: letter = 8'h76; // v
         8'h1D: letter = 8'h77; // w
         8'h22: letter = 8'h78; // x
         8'h35: letter = 8'h79; // y
         8'h1A: letter = 8'h7A; // z
         default: letter = 8'h00;
      endcase
      case (code)
         8'h45: other = 8'h30;
         8'h16: other = 8'h31;
         8'h1E: other = 8'h32;
         8'h26: other = 8'h33;
         8'h25: other = 8'h34;
         8'h2E: other = 8'h35;
         8'h36: other = 8'h36;
         8'h3D: other = 8'h37;
         8'h3E: other = 8'h38;
         8'h46: other = 8'h39;
         8'h29: other = 8'h20; // space
         default: other = 8'h00;
      endcase
      if (letter != 8'h00) begin
         return upper ? (letter - 8'h20) : letter;
      end
      return other;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO for decoded key events.
//   clk, clrn  : clock, asynchronous active-high reset
//   push_i     : write data_i (ignored when full)
//   data_i     : event to store
//   pop_i      : remove head (ignored when empty)
//   valid_o    : head entry is valid
//   data_o     : head entry, forced to 0 when empty
//   level_o    : number of occupied entries
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 18
) (
   input  logic                   clk,
   input  logic                   clrn,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic                   valid_o,
   output logic [WIDTH-1:0]       data_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && (level_q != '0);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      // Simultaneous push and pop leave the level unchanged.
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= data_i;
      end
   end

   assign valid_o = (level_q != '0);
   assign data_o  = valid_o ? mem_q[rptr_q] : '0;
   assign level_o = level_q;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: turns a PS/2 set 2 scan-byte stream into key events.
//   clk, clrn      : clock, asynchronous active-high reset
//   in_valid/ready : scan byte handshake from the receiver (back-pressure only)
//   in_data        : scan byte
//   out_valid/ready: event handshake towards the consumer
//   out_code/ext/release/ascii : head event fields
//   key_count      : accepted make events, wraps
//   shift, caps    : modifier state
//   fifo_level     : occupied event FIFO entries
// A decoded event sits one cycle in ev_q before being written to the FIFO,
// giving a two-cycle byte-to-out_valid latency.
module ps2_key_event_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned REPEAT_FILTER = 1
) (
   input  logic                        clk,
   input  logic                        clrn,
   input  logic                        in_valid,
   input  logic [7:0]                  in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [7:0]                  out_code,
   output logic                        out_ext,
   output logic                        out_release,
   output logic [7:0]                  out_ascii,
   output logic [CNT_W-1:0]            key_count,
   output logic                        shift,
   output logic                        caps,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW:0] DEPTH_L = (LW+1)'(FIFO_DEPTH);

   ps2_state_e       state_q, state_d;
   ps2_event_t       ev_q, ev_d;
   logic             push_q, push_d;
   logic [8:0]       held_q, held_d;
   logic             held_vld_q, held_vld_d;
   logic             lshift_q, lshift_d;
   logic             rshift_q, rshift_d;
   logic             caps_q, caps_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             byte_acc;
   logic             emit;
   logic             emit_ext;
   logic             emit_brk;
   logic             upper;
   logic [8:0]       key_id;
   logic             held_hit;
   logic             filtered;
   logic [LW:0]      occupancy;
   ps2_event_t       head_ev;

   // The staged event counts as occupied so a full FIFO never sees a push.
   assign occupancy = {1'b0, fifo_level} + {{LW{1'b0}}, push_q};
   assign in_ready  = (occupancy < DEPTH_L);
   assign byte_acc  = in_valid && in_ready;

   // Prefix decoding: decide whether this byte completes an event.
   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (byte_acc) begin
         unique case (state_q)
            IDLE: begin
               if (in_data == PS2_EXT) begin
                  state_d = EXT;
               end else if (in_data == PS2_BRK) begin
                  state_d = BRK;
               end else begin
                  emit = 1'b1;
               end
            end
            EXT: begin
               if (in_data == PS2_BRK) begin
                  state_d = EXT_BRK;
               end else if (in_data != PS2_EXT) begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  state_d  = IDLE;
               end
            end
            BRK: begin
               // A stray E0 after F0 does not promote to an extended break.
               if ((in_data != PS2_BRK) && (in_data != PS2_EXT)) begin
                  emit     = 1'b1;
                  emit_brk = 1'b1;
                  state_d  = IDLE;
               end
            end
            EXT_BRK: begin
               if ((in_data != PS2_BRK) && (in_data != PS2_EXT)) begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  emit_brk = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign upper    = (lshift_q | rshift_q) ^ caps_q;
   assign key_id   = {emit_ext, in_data};
   assign held_hit = held_vld_q && (held_q == key_id);
   assign filtered = (REPEAT_FILTER != 0) && held_hit;

   // Event construction and modifier/held/count updates. ASCII uses the
   // modifier state from before this event's own update.
   always_comb begin
      ev_d       = ev_q;
      push_d     = 1'b0;
      held_d     = held_q;
      held_vld_d = held_vld_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      caps_d     = caps_q;
      count_d    = count_q;
      if (emit) begin
         ev_d.ext      = emit_ext;
         ev_d.is_break = emit_brk;
         ev_d.code     = in_data;
         ev_d.ascii    = emit_ext ? 8'h00 : ps2_ascii(in_data, upper);
         if (!emit_brk) begin
            if (!filtered) begin
               push_d     = 1'b1;
               count_d    = count_q + CNT_W'(1);
               held_d     = key_id;
               held_vld_d = 1'b1;
               if (!emit_ext && (in_data == PS2_CAPS)) begin
                  caps_d = !caps_q;
               end
            end
            if (!emit_ext && (in_data == PS2_LSHIFT)) begin
               lshift_d = 1'b1;
            end
            if (!emit_ext && (in_data == PS2_RSHIFT)) begin
               rshift_d = 1'b1;
            end
         end else begin
            push_d = 1'b1;
            if (held_hit) begin
               held_vld_d = 1'b0;
            end
            if (!emit_ext && (in_data == PS2_LSHIFT)) begin
               lshift_d = 1'b0;
            end
            if (!emit_ext && (in_data == PS2_RSHIFT)) begin
               rshift_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         state_q    <= IDLE;
         ev_q       <= '0;
         push_q     <= 1'b0;
         held_q     <= '0;
         held_vld_q <= 1'b0;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         caps_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         ev_q       <= ev_d;
         push_q     <= push_d;
         held_q     <= held_d;
         held_vld_q <= held_vld_d;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         caps_q     <= caps_d;
         count_q    <= count_d;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_EVENT_W)
   ) u_fifo (
      .clk     (clk),
      .clrn    (clrn),
      .push_i  (push_q),
      .data_i  (ev_q),
      .pop_i   (out_ready),
      .valid_o (out_valid),
      .data_o  (head_ev),
      .level_o (fifo_level)
   );

   assign out_code    = head_ev.code;
   assign out_ext     = head_ev.ext;
   assign out_release = head_ev.is_break;
   assign out_ascii   = head_ev.ascii;
   assign key_count   = count_q;
   assign shift       = lshift_q | rshift_q;
   assign caps        = caps_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: two instances (repeat filter on / off) share
// one byte stream; a reference model fills per-instance expected-event queues
// and a monitor pops them as the DUTs present events.
module tb_ps2_key_event_decoder;

   localparam int NI = 2;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
      logic [7:0] ascii;
   } exp_ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       drv_valid;
   logic [7:0] drv_data;
   logic       v_acc;
   logic       hold_out;

   logic       rdy [NI];
   logic       ov  [NI];
   logic       ordy[NI];
   logic       oe  [NI];
   logic       orl [NI];
   logic       sh  [NI];
   logic       cp  [NI];
   logic [7:0] oc  [NI];
   logic [7:0] oa  [NI];
   logic [7:0] kc  [NI];
   logic [2:0] lvl [NI];

   always #5 clk = ~clk;

   // Both instances must accept each byte on the same edge.
   assign v_acc = drv_valid && rdy[0] && rdy[1];

   ps2_key_event_decoder #(
      .FIFO_DEPTH    (4),
      .CNT_W         (8),
      .REPEAT_FILTER (1)
   ) dut0 (
      .clk         (clk),
      .clrn        (rst),
      .in_valid    (v_acc),
      .in_data     (drv_data),
      .in_ready    (rdy[0]),
      .out_valid   (ov[0]),
      .out_ready   (ordy[0]),
      .out_code    (oc[0]),
      .out_ext     (oe[0]),
      .out_release (orl[0]),
      .out_ascii   (oa[0]),
      .key_count   (kc[0]),
      .shift       (sh[0]),
      .caps        (cp[0]),
      .fifo_level  (lvl[0])
   );

   ps2_key_event_decoder #(
      .FIFO_DEPTH    (4),
      .CNT_W         (8),
      .REPEAT_FILTER (0)
   ) dut1 (
      .clk         (clk),
      .clrn        (rst),
      .in_valid    (v_acc),
      .in_data     (drv_data),
      .in_ready    (rdy[1]),
      .out_valid   (ov[1]),
      .out_ready   (ordy[1]),
      .out_code    (oc[1]),
      .out_ext     (oe[1]),
      .out_release (orl[1]),
      .out_ascii   (oa[1]),
      .key_count   (kc[1]),
      .shift       (sh[1]),
      .caps        (cp[1]),
      .fifo_level  (lvl[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   exp_ev_t    exp0[$];
   exp_ev_t    exp1[$];
   logic [7:0] lut_lower[256];
   logic [7:0] lut_other[256];
   logic       m_ext, m_brk;
   logic       m_lsh[NI], m_rsh[NI], m_caps[NI], m_held_v[NI];
   logic [8:0] m_held[NI];
   logic [7:0] m_cnt[NI];

   function automatic logic [7:0] ref_ascii(input logic [7:0] code, input logic up);
      if (lut_lower[code] != 8'h00) return up ? (lut_lower[code] - 8'h20) : lut_lower[code];
      return lut_other[code];
   endfunction

   task automatic push_exp(input int i, input exp_ev_t e);
      if (i == 0) exp0.push_back(e);
      else exp1.push_back(e);
   endtask

   task automatic pop_exp(input int i, output exp_ev_t e, output bit ok);
      ok = 1'b0;
      e  = '0;
      if (i == 0 && exp0.size() != 0) begin e = exp0.pop_front(); ok = 1'b1; end
      if (i == 1 && exp1.size() != 0) begin e = exp1.pop_front(); ok = 1'b1; end
   endtask

   task automatic model_clear();
      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int i = 0; i < NI; i++) begin
         m_lsh[i] = 1'b0; m_rsh[i] = 1'b0; m_caps[i] = 1'b0;
         m_held_v[i] = 1'b0; m_held[i] = '0; m_cnt[i] = 8'h00;
      end
   endtask

   task automatic model_emit(input logic ext, input logic brk, input logic [7:0] code);
      for (int i = 0; i < NI; i++) begin
         exp_ev_t    e;
         logic [8:0] key;
         logic       filt;
         key     = {ext, code};
         e.ext   = ext;
         e.brk   = brk;
         e.code  = code;
         e.ascii = ext ? 8'h00 : ref_ascii(code, (m_lsh[i] | m_rsh[i]) ^ m_caps[i]);
         if (!brk) begin
            filt = (i == 0) && m_held_v[i] && (m_held[i] == key);
            if (!filt) begin
               push_exp(i, e);
               m_cnt[i]    = m_cnt[i] + 8'd1;
               m_held[i]   = key;
               m_held_v[i] = 1'b1;
               if (!ext && code == 8'h58) m_caps[i] = !m_caps[i];
            end
            if (!ext && code == 8'h12) m_lsh[i] = 1'b1;
            if (!ext && code == 8'h59) m_rsh[i] = 1'b1;
         end else begin
            push_exp(i, e);
            if (m_held_v[i] && m_held[i] == key) m_held_v[i] = 1'b0;
            if (!ext && code == 8'h12) m_lsh[i] = 1'b0;
            if (!ext && code == 8'h59) m_rsh[i] = 1'b0;
         end
      end
   endtask

   // E0 marks extended unless a break prefix is already pending.
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) begin
         if (!m_brk) m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         model_emit(m_ext, m_brk, b);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   // ---------------- monitor ----------------
   exp_ev_t snap[NI];
   bit      stalled[NI];

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) ordy[i] = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < NI; i++) begin
         exp_ev_t cur;
         exp_ev_t e;
         bit      ok;
         cur = '{ext: oe[i], brk: orl[i], code: oc[i], ascii: oa[i]};
         if (rst) begin
            stalled[i] = 1'b0;
         end else if (ov[i]) begin
            if (stalled[i]) check($sformatf("hold_stable_%0d", i), 32'(cur), 32'(snap[i]));
            if (ordy[i]) begin
               pop_exp(i, e, ok);
               if (!ok) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event_%0d: got %h, expected no event", i, cur);
               end else begin
                  check($sformatf("event_%0d", i), 32'(cur), 32'(e));
               end
               stalled[i] = 1'b0;
            end else begin
               stalled[i] = 1'b1;
               snap[i]    = cur;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      drv_data  = b;
      drv_valid = 1'b1;
      while (!(rdy[0] && rdy[1]) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h in_ready %b/%b, expected 1", b, rdy[0], rdy[1]);
         drv_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_byte(b);
      #1 drv_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[k]) send_byte(s[k]);
   endtask

   task automatic drain();
      int n = 0;
      hold_out = 1'b0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("drain_pending_0", exp0.size(), 0);
      check("drain_pending_1", exp1.size(), 0);
      for (int i = 0; i < NI; i++) check($sformatf("drain_level_%0d", i), lvl[i], 0);
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s_key_count_%0d", tag, i), kc[i], m_cnt[i]);
         check($sformatf("%s_shift_%0d", tag, i), sh[i], m_lsh[i] | m_rsh[i]);
         check($sformatf("%s_caps_%0d", tag, i), cp[i], m_caps[i]);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      drv_valid = 1'b0;
      exp0.delete();
      exp1.delete();
      model_clear();
      repeat (2) @(negedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_out_valid_%0d", i), ov[i], 0);
         check($sformatf("rst_fifo_level_%0d", i), lvl[i], 0);
         check($sformatf("rst_key_count_%0d", i), kc[i], 0);
         check($sformatf("rst_mods_%0d", i), {sh[i], cp[i]}, 0);
         check($sformatf("rst_in_ready_%0d", i), rdy[i], 1);
         check($sformatf("rst_out_fields_%0d", i), {oc[i], oa[i], oe[i], orl[i]}, 0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
         8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
         8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
         8'h3D, 8'h3E, 8'h46};
      logic [7:0] pool[18] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h45, 8'h16, 8'h29, 8'h12,
         8'h59, 8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h6B, 8'h1A, 8'h66, 8'h5A};

      for (int k = 0; k < 256; k++) begin
         lut_lower[k] = 8'h00;
         lut_other[k] = 8'h00;
      end
      for (int k = 0; k < 26; k++) lut_lower[letter_codes[k]] = 8'h61 + 8'(k);
      for (int k = 0; k < 10; k++) lut_other[digit_codes[k]] = 8'h30 + 8'(k);
      lut_other[8'h29] = 8'h20;

      rst       = 1'b1;
      hold_out  = 1'b1;
      drv_valid = 1'b0;
      drv_data  = 8'h00;
      model_clear();

      // Make/break of 'a' with latency check on the first byte.
      do_reset();
      hold_out = 1'b1;
      send_byte(8'h1C);
      check("latency_c1_out_valid", ov[0], 0);
      @(negedge clk);
      check("latency_c2_out_valid", ov[0], 1);
      send_seq('{8'hF0, 8'h1C});
      drain();
      check("t1_key_count", kc[0], 8'd1);
      check_state("t1");

      // Shift gives uppercase.
      do_reset();
      send_byte(8'h12);
      check("t2_shift_held", sh[0], 1);
      send_seq('{8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
      check("t2_shift_released", sh[0], 0);
      drain();
      check("t2_key_count", kc[0], 8'd2);

      // Caps lock, then shift cancelling caps.
      do_reset();
      send_seq('{8'h58, 8'hF0, 8'h58, 8'h1C});
      check("t3_caps_on", cp[0], 1);
      send_seq('{8'h12, 8'h1C});
      drain();
      check_state("t3");

      // Typematic repeat filtering.
      do_reset();
      send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
      drain();
      check("t4_count_filtered", kc[0], 8'd1);
      check("t4_count_unfiltered", kc[1], 8'd3);

      // Extended make/break, then reset discarding a pending E0.
      do_reset();
      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      drain();
      send_byte(8'hE0);
      do_reset();
      send_seq('{8'hF0, 8'h75});
      drain();
      check_state("t5");

      // Back-pressure with a full FIFO.
      do_reset();
      hold_out = 1'b1;
      send_seq('{8'h1C, 8'h32, 8'h21, 8'h23});
      fork
         send_byte(8'h24);
         begin
            repeat (4) @(negedge clk);
            #2;
            check("bp_level_0", lvl[0], 4);
            check("bp_level_1", lvl[1], 4);
            check("bp_in_ready", rdy[0], 0);
            check("bp_count_before", kc[0], 8'd4);
            hold_out = 1'b0;
         end
      join
      drain();
      check("bp_count_after", kc[0], 8'd5);

      // key_count wrap.
      do_reset();
      hold_out = 1'b0;
      for (int k = 0; k < 255; k++) send_byte(k[0] ? 8'h32 : 8'h1C);
      check("wrap_count_ff_0", kc[0], 8'hFF);
      check("wrap_count_ff_1", kc[1], 8'hFF);
      send_byte(8'h32);
      check("wrap_count_00_0", kc[0], 8'h00);
      check("wrap_count_00_1", kc[1], 8'h00);
      drain();

      // Randomised stream against the model.
      do_reset();
      hold_out = 1'b0;
      for (int k = 0; k < 400; k++) begin
         send_byte(pool[$urandom_range(0, 17)]);
         if (k % 25 == 24) check_state("rand");
      end
      drain();
      check_state("rand_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Sits between the PS/2 byte receiver (ps2_keyboard) and the display/consumer logic.
- Turns the raw scan-code byte stream into whole key events (make or break, normal or E0-extended) with an ASCII translation.
- Tracks shift/caps modifier state, filters typematic repeats, counts key presses and buffers events in a parametrised FIFO with a valid/ready output.
- Replaces ad-hoc per-top state machines with one reusable block.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
CNT_W, 8, width of key_count; wraps modulo 2^CNT_W
REPEAT_FILTER, 1, 1 = suppress repeated make of a key already held; 0 = pass every make

Ports:
clk  input  1  system clock
clrn  input  1  reset, asynchronous, active-high
in_valid  input  1  scan byte available from receiver
in_data  input  8  scan byte
in_ready  output  1  byte accepted when in_valid && in_ready (drives receiver pop)
out_valid  output  1  FIFO head event valid
out_ready  input  1  consumer pops head when out_valid && out_ready
out_code  output  8  scan code of head event
out_ext  output  1  head event was E0-prefixed
out_release  output  1  head event is a break
out_ascii  output  8  ASCII of head event, 0 if unmapped
key_count  output  CNT_W  accepted (non-filtered) make events
shift  output  1  left (0x12) or right (0x59) shift held
caps  output  1  caps-lock toggle state
fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (clrn=1, async): prefix FSM=IDLE, FIFO empty, out_valid=0, out_* = 0, key_count=0, shift=0, caps=0, held-key register invalid, fifo_level=0. Reset mid-sequence discards any pending E0/F0 prefix.
- in_ready = !fifo_full (combinational). No byte is ever dropped; back-pressure only.
- Prefix FSM advances only on accepted bytes:
  - IDLE: E0→EXT, F0→BRK, other→emit(make, ext=0), stay IDLE.
  - EXT: F0→EXT_BRK, E0→EXT, other→emit(make, ext=1)→IDLE.
  - BRK: F0/E0→BRK (ignored), other→emit(break, ext=0)→IDLE.
  - EXT_BRK: F0/E0→EXT_BRK, other→emit(break, ext=1)→IDLE.
- Emit (make):
  - If REPEAT_FILTER and {ext,code} == held register: no push, no count.
  - Otherwise push, key_count+1 (wraps), held←{ext,code}.
  - Non-ext 0x12/0x59 set the corresponding shift bit. Non-ext 0x58 toggles caps only on a non-filtered make.
- Emit (break): always push. Clear held if it matches. Non-ext 0x12/0x59 clear the corresponding shift bit.
- The event is pushed in the cycle after the final byte is accepted. out_valid rises the following cycle, so byte-to-out_valid latency is 2 cycles.
- ASCII (non-ext only; ext → 0):
  - Letters 0x1C..'a' map as in the standard set 2 table.
  - Uppercase (subtract 0x20) when shift XOR caps.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → '0'..'9' regardless of shift.
  - 0x29 → 0x20 (space). All else → 0.
  - Translation uses modifier state at emit time, before this event's own modifier update.
- FIFO: push and pop in the same cycle allowed when not full; level unchanged. Pop on empty is ignored. When full, push cannot occur because in_ready=0. Read and write pointers wrap modulo FIFO_DEPTH.
- out_* hold stable while out_valid && !out_ready.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59, PS2_CAPS=8'h58;
  - the prefix-state enum {IDLE, EXT, BRK, EXT_BRK};
  - the event struct {ext, release, code, ascii};
  - the function ps2_ascii(code, upper).
- One sub-module, ps2_event_fifo: parametrised synchronous FIFO on the event struct, with level output.

Test Plan:
- Bytes 1C,F0,1C → events {make,1C,'a'=61}, {break,1C,61}; key_count=1; 2-cycle latency from the last byte to out_valid.
- 12,1C,F0,1C,F0,12 → second event ascii=41 ('A'); shift=1 during, 0 after; key_count=2.
- 58,F0,58,1C → caps=1, 1C gives ascii=41; then 12,1C (shift+caps) gives ascii=61.
- REPEAT_FILTER=1: 1C,1C,1C,F0,1C → only make+break pushed, key_count=1; REPEAT_FILTER=0 → 3 makes, key_count=3.
- E0,75,E0,F0,75 → {make,ext=1,75,ascii=0}, {break,ext=1,75,0}; assert clrn between E0 and F0 → no event, FSM IDLE.
- out_ready=0 with 5 make codes, FIFO_DEPTH=4 → fifo_level=4, in_ready=0, 5th byte held; pop one → byte accepted, order preserved; key_count (CNT_W=8) at 8'hFF + 1 make → 8'h00.
